regfile_port_sequencer: RTL and testbench
=========================================

REGFILE_PORT_SEQUENCER -- requirements
Module: regfile_port_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, data width of the register file.
REQ-002 Parameter ADDR_W, default 5, register address width (32 entries).
REQ-003 Parameter RD_SETTLE, default 2, range 1..15, cycles read addresses are held before capture.
REQ-004 Parameter WR_PULSE, default 1, range 1..15, cycles rf_mode is held high per write.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  sequencer accepts a request this cycle.
REQ-009 req_op  in  1  0 = read pair, 1 = write.
REQ-010 req_raddr1, req_raddr2  in  ADDR_W each  read addresses.
REQ-011 req_waddr  in  ADDR_W  write address; req_wdata  in  DATA_W  write value.
REQ-012 rsp_valid  out  1  response present; rsp_ready  in  1  consumer takes response.
REQ-013 rsp_op  out  1  echo of accepted req_op.
REQ-014 rsp_rdata1, rsp_rdata2  out  DATA_W each  captured read data.
REQ-015 rf_mode  out  1  register-file mode, 0 = read, 1 = write.
REQ-016 rf_waddr  out  ADDR_W; rf_wdata  out  DATA_W  register-file write port.
REQ-017 rf_raddr1, rf_raddr2  out  ADDR_W each  register-file read addresses.
REQ-018 rf_rdata1, rf_rdata2  in  DATA_W each  register-file read data, combinational from rf_raddr*.

Function
REQ-019 FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RSP; all outputs driven from registers.
REQ-020 req_ready is 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-021 On acceptance, all req_* fields are latched; later changes to req_* have no effect until the next acceptance.
REQ-022 Read accept: go to RD_WAIT; rf_raddr1/2 = latched addresses from the next cycle; rf_mode = 0.
REQ-023 RD_WAIT lasts exactly RD_SETTLE cycles; on its last edge rf_rdata1/2 are captured into rsp_rdata1/2; go to RSP.
REQ-024 Read latency: accept at edge T -> rsp_valid = 1 in the cycle after edge T+RD_SETTLE.
REQ-025 Write accept: go to WR_SETUP (1 cycle, rf_mode = 0, rf_waddr/rf_wdata driven).
REQ-026 WR_PULSE: rf_mode = 1 for exactly WR_PULSE cycles; rf_waddr/rf_wdata unchanged.
REQ-027 WR_HOLD: 1 cycle, rf_mode = 0, rf_waddr/rf_wdata unchanged; then RSP.
REQ-028 Write response: rsp_rdata1/2 = 0; write latency accept -> rsp_valid = WR_PULSE + 3 cycles.
REQ-029 rf_waddr/rf_wdata shall not change while rf_mode = 1, nor in the cycle before or after it.
REQ-030 rf_mode shall be 0 in every state except WR_PULSE.
REQ-031 RSP: rsp_valid = 1 and rsp_* stable until rsp_valid & rsp_ready at an edge; then IDLE.
REQ-032 No request is accepted in the same cycle a response is consumed; there is one idle cycle minimum between transactions.
REQ-033 rf_raddr1/2 hold their last value outside RD_WAIT.
REQ-034 A read of the address just written returns the written value; no bypass logic, ordering alone guarantees this.
REQ-035 A phase counter is sized to 4 bits; it saturates nowhere and reloads on each state entry.

Reset
REQ-036 rst_n = 0 at an edge: state = IDLE, rf_mode = 0, req_ready = 1 from the next cycle if rst_n = 1.
REQ-037 While rst_n = 0: req_ready = 0, rsp_valid = 0, rsp_op = 0, rsp_rdata1/2 = 0, rf_waddr/rf_wdata/rf_raddr1/2 = 0.
REQ-038 Reset during WR_PULSE drops rf_mode to 0 at that edge; the in-flight transaction is discarded with no response.

Verification
REQ-039 Write addr 5 data 0xDEADBEEF, then read raddr1 = 5, raddr2 = 0 -> rsp_rdata1 = 0xDEADBEEF, rsp_rdata2 = reg0 contents.
REQ-040 Write with WR_PULSE = 3 -> rf_mode high exactly 3 cycles; rf_waddr/rf_wdata stable one cycle before through one cycle after; rsp_valid 6 cycles after accept.
REQ-041 Read with RD_SETTLE = 2, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles, and req_ready = 0 throughout.
REQ-042 req_valid held high with changing fields -> exactly one acceptance per transaction, and rsp data matches the fields at the acceptance edge.
REQ-043 rst_n low during the second WR_PULSE cycle -> rf_mode = 0 after that edge, no rsp_valid, and req_ready = 1 after rst_n returns high.
REQ-044 32 writes of value addr*0x01010101, then 16 dual reads -> every rsp_rdata matches its address.

Source files
------------

// File: rtl/regfile_port_sequencer.sv
// Request/response sequencer that drives a single-mode register-file port:
// reads hold addresses for a settle window, writes get setup/pulse/hold phases.
module regfile_port_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned RD_SETTLE = 2,
  parameter int unsigned WR_PULSE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_raddr1,
  input  logic [ADDR_W-1:0] req_raddr2,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [DATA_W-1:0] rsp_rdata2,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_RSP      = 3'd5;

  localparam int unsigned PH_W = 4;
  localparam logic [PH_W-1:0] RD_LAST = PH_W'(RD_SETTLE - 1);
  localparam logic [PH_W-1:0] WR_LAST = PH_W'(WR_PULSE - 1);

  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_op_q, rsp_op_d;
  logic [DATA_W-1:0] rsp_rdata1_q, rsp_rdata1_d;
  logic [DATA_W-1:0] rsp_rdata2_q, rsp_rdata2_d;
  logic              rf_mode_q, rf_mode_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [ADDR_W-1:0] rf_raddr1_q, rf_raddr1_d;
  logic [ADDR_W-1:0] rf_raddr2_q, rf_raddr2_d;

  // Next-state and next-output logic; phase counts down to zero and reloads on entry.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rsp_op_d     = rsp_op_q;
    rsp_rdata1_d = rsp_rdata1_q;
    rsp_rdata2_d = rsp_rdata2_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_raddr1_d  = rf_raddr1_q;
    rf_raddr2_d  = rf_raddr2_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          rsp_op_d = req_op;
          if (req_op) begin
            state_d      = S_WR_SETUP;
            phase_d      = '0;
            rf_waddr_d   = req_waddr;
            rf_wdata_d   = req_wdata;
            rsp_rdata1_d = '0;
            rsp_rdata2_d = '0;
          end else begin
            state_d     = S_RD_WAIT;
            phase_d     = RD_LAST;
            rf_raddr1_d = req_raddr1;
            rf_raddr2_d = req_raddr2;
          end
        end
      end
      S_RD_WAIT: begin
        if (phase_q == '0) begin
          state_d      = S_RSP;
          phase_d      = '0;
          rsp_rdata1_d = rf_rdata1;
          rsp_rdata2_d = rf_rdata2;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        phase_d = WR_LAST;
      end
      S_WR_PULSE: begin
        if (phase_q == '0) begin
          state_d = S_WR_HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_RSP;
        phase_d = '0;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
    rf_mode_d   = (state_d == S_WR_PULSE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 1'b0;
      rsp_rdata1_q <= '0;
      rsp_rdata2_q <= '0;
      rf_mode_q    <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_raddr1_q  <= '0;
      rf_raddr2_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_rdata1_q <= rsp_rdata1_d;
      rsp_rdata2_q <= rsp_rdata2_d;
      rf_mode_q    <= rf_mode_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_raddr1_q  <= rf_raddr1_d;
      rf_raddr2_q  <= rf_raddr2_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_rdata1 = rsp_rdata1_q;
  assign rsp_rdata2 = rsp_rdata2_q;
  assign rf_mode    = rf_mode_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_raddr1  = rf_raddr1_q;
  assign rf_raddr2  = rf_raddr2_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Randomized bench: a transaction-timeline model plus a behavioural register
// file, compared against the sequencer on every falling edge.
module tb_regfile_port_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RS = 2;
  localparam int unsigned WP = 3;
  localparam int unsigned NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_op;
  logic [AW-1:0] req_raddr1, req_raddr2, req_waddr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_op;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2;
  logic          rf_mode;
  logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] seed_mem [NREG];
  logic [DW-1:0] env_mem  [NREG];
  logic [DW-1:0] golden   [NREG];
  logic          mem_load;

  regfile_port_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .RD_SETTLE(RS), .WR_PULSE(WP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .rf_mode(rf_mode), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  always #5 clk = ~clk;

  // Register file attached to the port: combinational read, write on rf_mode.
  assign rf_rdata1 = env_mem[rf_raddr1];
  assign rf_rdata2 = env_mem[rf_raddr2];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < NREG; i++) env_mem[i] <= seed_mem[i];
    end else if (rf_mode) begin
      env_mem[rf_waddr] <= rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Transaction model: each accepted request follows a fixed timeline measured
  // in edges since acceptance; results come from a golden array updated at accept.
  bit            started = 0;
  bit            m_in_reset, busy, m_ready;
  int            age, lat;
  logic          m_op;
  logic [AW-1:0] m_r1, m_r2, m_wa;
  logic [DW-1:0] m_wd, m_rd1, m_rd2;
  logic          m_rsp_op;

  always @(posedge clk) begin
    if (!rst_n) begin
      if (mem_load) for (int i = 0; i < NREG; i++) golden[i] = seed_mem[i];
      started = 1; m_in_reset = 1; busy = 0; m_ready = 0;
      age = 0; lat = 0; m_op = 0;
      m_r1 = '0; m_r2 = '0; m_wa = '0; m_wd = '0;
      m_rd1 = '0; m_rd2 = '0; m_rsp_op = 0;
    end else if (started) begin
      m_in_reset = 0;
      if (busy) begin
        if (age >= lat && rsp_ready) busy = 0;
        else age++;
      end else if (m_ready && req_valid) begin
        busy = 1; age = 1; m_op = req_op; m_rsp_op = req_op;
        if (req_op) begin
          lat = WP + 3;
          m_wa = req_waddr; m_wd = req_wdata;
          golden[req_waddr] = req_wdata;
          m_rd1 = '0; m_rd2 = '0;
        end else begin
          lat = RS + 1;
          m_r1 = req_raddr1; m_r2 = req_raddr2;
          m_rd1 = golden[req_raddr1]; m_rd2 = golden[req_raddr2];
        end
      end
      m_ready = !busy;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic bit exp_valid = busy && age >= lat;
      automatic bit exp_mode  = busy && m_op && age >= 2 && age <= WP + 1;
      chk("req_ready", 64'(req_ready), 64'(m_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      chk("rf_mode",   64'(rf_mode),   64'(exp_mode));
      chk("rf_raddr1", 64'(rf_raddr1), 64'(m_r1));
      chk("rf_raddr2", 64'(rf_raddr2), 64'(m_r2));
      if (exp_valid || m_in_reset) begin
        chk("rsp_op",     64'(rsp_op),     64'(m_rsp_op));
        chk("rsp_rdata1", 64'(rsp_rdata1), 64'(m_rd1));
        chk("rsp_rdata2", 64'(rsp_rdata2), 64'(m_rd2));
      end
      if (m_in_reset || (busy && m_op && age <= WP + 2)) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wd));
      end
    end
  end

  // Issue one request and retire its response; called just after a falling edge.
  task automatic send(input logic op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int stall,
                      output int lat_cyc, output int mode_cyc,
                      output logic [DW-1:0] d1, output logic [DW-1:0] d2);
    int n = 0;
    lat_cyc = 0; mode_cyc = 0; d1 = '0; d2 = '0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin timeout("ready_wait"); return; end
    req_valid = 1; req_op = op; req_raddr1 = r1; req_raddr2 = r2;
    req_waddr = wa; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_op = 1'($urandom); req_raddr1 = AW'($urandom);
    req_raddr2 = AW'($urandom); req_waddr = AW'($urandom); req_wdata = $urandom;
    lat_cyc = 1; mode_cyc = int'(rf_mode);
    while (!rsp_valid && lat_cyc < 200) begin
      @(negedge clk); lat_cyc++; mode_cyc += int'(rf_mode);
    end
    if (!rsp_valid) begin timeout("rsp_wait"); return; end
    d1 = rsp_rdata1; d2 = rsp_rdata2;
    repeat (stall) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_c, mode_c, n, seen;
    logic [DW-1:0] d1, d2, ex;
    logic [AW-1:0] a;
    for (int i = 0; i < NREG; i++) seed_mem[i] = $urandom;
    rst_n = 0; mem_load = 1; req_valid = 0; rsp_ready = 0; req_op = 0;
    req_raddr1 = '0; req_raddr2 = '0; req_waddr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rf_wdata",  64'(rf_wdata),  64'd0);
    mem_load = 0; rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Write then read back the same register.
    send(1'b1, '0, '0, AW'(5), 32'hDEADBEEF, 0, lat_c, mode_c, d1, d2);
    chk("wr_latency",   64'(lat_c),  64'd6);
    chk("wr_pulse_len", 64'(mode_c), 64'd3);
    chk("wr_rdata1",    64'(d1),     64'd0);
    send(1'b0, AW'(5), AW'(0), '0, '0, 0, lat_c, mode_c, d1, d2);
    chk("rd_latency", 64'(lat_c), 64'd3);
    chk("rd_mode",    64'(mode_c), 64'd0);
    chk("rd_reg5",    64'(d1), 64'hDEADBEEF);
    chk("rd_reg0",    64'(d2), 64'(seed_mem[0]));

    // Response stalled for five cycles.
    send(1'b0, AW'(7), AW'(9), '0, '0, 5, lat_c, mode_c, d1, d2);

    // Reset in the second write-pulse cycle.
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_op = 1; req_waddr = AW'(12); req_wdata = $urandom;
    @(negedge clk);
    req_valid = 0;
    seen = int'(rf_mode); n = 0;
    while (seen < 2 && n < 50) begin
      @(negedge clk); n++; seen += int'(rf_mode);
    end
    if (seen < 2) timeout("pulse_wait");
    rst_n = 0;
    @(negedge clk);
    chk("rstp_rf_mode",   64'(rf_mode),   64'd0);
    chk("rstp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstp_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rstp_ready_back", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);

    // Fill every register with addr*0x01010101, then read pairs back.
    for (int i = 0; i < NREG; i++) begin
      a = AW'(i);
      send(1'b1, '0, '0, a, DW'(i) * 32'h01010101, 0, lat_c, mode_c, d1, d2);
    end
    for (int i = 0; i < 16; i++) begin
      send(1'b0, AW'(2 * i), AW'(2 * i + 1), '0, '0, 0, lat_c, mode_c, d1, d2);
      ex = DW'(2 * i) * 32'h01010101;
      chk("fill_rd1", 64'(d1), 64'(ex));
      ex = DW'(2 * i + 1) * 32'h01010101;
      chk("fill_rd2", 64'(d2), 64'(ex));
    end

    // req_valid held high while fields change every cycle.
    req_valid = 1;
    for (int c = 0; c < 150; c++) begin
      req_op = 1'($urandom); req_raddr1 = AW'($urandom); req_raddr2 = AW'($urandom);
      req_waddr = AW'($urandom); req_wdata = $urandom;
      rsp_ready = 1'($urandom);
      @(negedge clk);
    end
    req_valid = 0; rsp_ready = 1; n = 0;
    while (!(req_ready && !rsp_valid) && n < 50) begin @(negedge clk); n++; end
    chk("drain_idle", 64'(req_ready), 64'd1);
    rsp_ready = 0;

    // Random mix of transactions with random response stalls.
    for (int t = 0; t < 200; t++) begin
      send(1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), $urandom,
           int'($urandom_range(0, 3)), lat_c, mode_c, d1, d2);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
